// File: rtl/keyboard_ps2_decoder.sv
// PS/2 keyboard receiver and set-2 make-code decoder.
// Synchronizes and deglitches the device clock, assembles 11-bit frames
// (start, 8 data LSB-first, odd parity, stop), then tracks shift, caps-lock,
// break and extended prefixes to report plain make codes with a letter-case flag.
module keyboard_ps2_decoder #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       key_valid,
    output logic       letter_case,
    output logic       caps_lock,
    output logic       frame_err
);

    localparam int unsigned FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
    localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] CodeBreak  = 8'hF0;
    localparam logic [7:0] CodeExt    = 8'hE0;
    localparam logic [7:0] CodeLShift = 8'h12;
    localparam logic [7:0] CodeRShift = 8'h59;
    localparam logic [7:0] CodeCaps   = 8'h58;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } rx_state_e;

    // Synchronizers and clock filter
    logic           clk_s1_q, clk_s2_q;
    logic           data_s1_q, data_s2_q;
    logic           filt_q, filt_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;
    logic           fall;

    // Frame receiver
    rx_state_e      state_q, state_d;
    logic [2:0]     bitcnt_q, bitcnt_d;
    logic [7:0]     shreg_q, shreg_d;
    logic           par_q, par_d;
    logic [TCW-1:0] tmo_q, tmo_d;
    logic           byte_vld_q, byte_vld_d;
    logic [7:0]     byte_q, byte_d;
    logic           ferr_q, ferr_d;

    // Decoder state
    logic           lshift_q, lshift_d;
    logic           rshift_q, rshift_d;
    logic           caps_q, caps_d;
    logic           caps_held_q, caps_held_d;
    logic           brk_q, brk_d;
    logic           ext_q, ext_d;
    logic [7:0]     scan_q, scan_d;
    logic           case_q, case_d;
    logic           kv_q, kv_d;

    // Two-flop synchronizers; idle PS/2 lines are high, so reset to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            data_s1_q <= 1'b1;
            data_s2_q <= 1'b1;
        end else begin
            clk_s1_q  <= ps2_clk;
            clk_s2_q  <= clk_s1_q;
            data_s1_q <= ps2_data;
            data_s2_q <= data_s1_q;
        end
    end

    // Filtered level flips only after FILTER_LEN consecutive differing samples.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
                filt_d = clk_s2_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    // Falling edge is the cycle in which the filter decides to go 1->0.
    assign fall = filt_q & ~filt_d;

    // Frame receiver next state, with inter-edge watchdog outside IDLE.
    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        byte_d     = byte_q;
        byte_vld_d = 1'b0;
        ferr_d     = 1'b0;

        if (state_q == StIdle || fall) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                // A high start bit is line noise; ignore it silently.
                if (fall && !data_s2_q) begin
                    state_d  = StData;
                    bitcnt_d = '0;
                end
            end
            StData: begin
                if (fall) begin
                    shreg_d  = {data_s2_q, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = StParity;
                    end
                end
            end
            StParity: begin
                if (fall) begin
                    par_d   = data_s2_q;
                    state_d = StStop;
                end
            end
            StStop: begin
                if (fall) begin
                    state_d = StIdle;
                    if (data_s2_q && (^{shreg_q, par_q})) begin
                        byte_d     = shreg_q;
                        byte_vld_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_q != StIdle && !fall && tmo_q == TCW'(TIMEOUT_CYCLES - 1)) begin
            state_d = StIdle;
            ferr_d  = 1'b1;
            tmo_d   = '0;
        end
    end

    // Byte decoder: prefixes, modifier tracking and make-code reporting.
    always_comb begin
        lshift_d    = lshift_q;
        rshift_d    = rshift_q;
        caps_d      = caps_q;
        caps_held_d = caps_held_q;
        brk_d       = brk_q;
        ext_d       = ext_q;
        scan_d      = scan_q;
        case_d      = case_q;
        kv_d        = 1'b0;

        if (byte_vld_q) begin
            if (byte_q == CodeBreak) begin
                // Keeps ext_q so E0 F0 xx is still swallowed as extended.
                brk_d = 1'b1;
            end else if (byte_q == CodeExt) begin
                ext_d = 1'b1;
            end else if (ext_q) begin
                ext_d = 1'b0;
                brk_d = 1'b0;
            end else if (brk_q) begin
                brk_d = 1'b0;
                case (byte_q)
                    CodeLShift: lshift_d    = 1'b0;
                    CodeRShift: rshift_d    = 1'b0;
                    CodeCaps:   caps_held_d = 1'b0;
                    default:    ;
                endcase
            end else begin
                case (byte_q)
                    CodeLShift: lshift_d = 1'b1;
                    CodeRShift: rshift_d = 1'b1;
                    CodeCaps: begin
                        // Typematic repeats of caps arrive with caps_held set.
                        if (!caps_held_q) begin
                            caps_d = ~caps_q;
                        end
                        caps_held_d = 1'b1;
                    end
                    default: begin
                        scan_d = byte_q;
                        case_d = (lshift_q | rshift_q) ^ caps_q;
                        kv_d   = 1'b1;
                    end
                endcase
            end
        end
    end

    // State registers for filter, receiver and decoder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q      <= 1'b1;
            fcnt_q      <= '0;
            state_q     <= StIdle;
            bitcnt_q    <= '0;
            shreg_q     <= '0;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            byte_q      <= '0;
            byte_vld_q  <= 1'b0;
            ferr_q      <= 1'b0;
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            caps_q      <= 1'b0;
            caps_held_q <= 1'b0;
            brk_q       <= 1'b0;
            ext_q       <= 1'b0;
            scan_q      <= '0;
            case_q      <= 1'b0;
            kv_q        <= 1'b0;
        end else begin
            filt_q      <= filt_d;
            fcnt_q      <= fcnt_d;
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            par_q       <= par_d;
            tmo_q       <= tmo_d;
            byte_q      <= byte_d;
            byte_vld_q  <= byte_vld_d;
            ferr_q      <= ferr_d;
            lshift_q    <= lshift_d;
            rshift_q    <= rshift_d;
            caps_q      <= caps_d;
            caps_held_q <= caps_held_d;
            brk_q       <= brk_d;
            ext_q       <= ext_d;
            scan_q      <= scan_d;
            case_q      <= case_d;
            kv_q        <= kv_d;
        end
    end

    assign scan_code   = scan_q;
    assign key_valid   = kv_q;
    assign letter_case = case_q;
    assign caps_lock   = caps_q;
    assign frame_err   = ferr_q;

endmodule

// File: tb/tb_keyboard_ps2_decoder.sv
// Self-checking bench: PS/2 frame driver, report scoreboard and strobe monitor.
module tb_keyboard_ps2_decoder;

    localparam int unsigned FILT = 8;
    localparam int unsigned TMO  = 2000;
    localparam int unsigned HALF = 40;

    logic       clk;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] scan_code;
    logic       key_valid;
    logic       letter_case;
    logic       caps_lock;
    logic       frame_err;

    int checks   = 0;
    int failures = 0;
    int err_seen = 0;
    int err_exp  = 0;
    int prev_ferr = 0;
    int prev_kv   = 0;

    // {letter_case, scan_code} of each expected report
    logic [8:0] sb_q[$];

    keyboard_ps2_decoder #(
        .FILTER_LEN     (FILT),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .scan_code   (scan_code),
        .key_valid   (key_valid),
        .letter_case (letter_case),
        .caps_lock   (caps_lock),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Report scoreboard and strobe-shape monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (key_valid) begin
                check("kv_ferr_excl", {31'd0, frame_err}, 32'd0);
                check("kv_width", prev_kv, 0);
                check("kv_expected", {31'd0, sb_q.size() != 0}, 32'd1);
                if (sb_q.size() != 0) begin
                    logic [8:0] e;
                    e = sb_q.pop_front();
                    check("scan_code", {24'd0, scan_code}, {24'd0, e[7:0]});
                    check("letter_case", {31'd0, letter_case}, {31'd0, e[8]});
                end
            end
            if (frame_err) begin
                err_seen++;
                check("ferr_width", prev_ferr, 0);
            end
        end
        prev_ferr = int'(frame_err);
        prev_kv   = int'(key_valid);
    end

    // One PS/2 bit: data set, high phase (optionally glitched), then low phase.
    task automatic ps2_bit(input logic b, input bit glitch);
        @(negedge clk);
        ps2_data = b;
        if (glitch) begin
            repeat (10) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (3) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (HALF - 13) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    // Full frame; when a report is expected the stop-edge latency is measured:
    // 2 sync flops + FILTER_LEN filter samples + 1 decode stage.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit rep, input logic cs, input bit glitch);
        logic [10:0] bits;
        int lat;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        if (rep) sb_q.push_back({cs, b});
        for (int i = 0; i < 10; i++) ps2_bit(bits[i], glitch);
        @(negedge clk);
        ps2_data = bits[10];
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        lat = 0;
        for (int k = 1; k <= int'(HALF); k++) begin
            @(negedge clk);
            if (key_valid && lat == 0) lat = k;
        end
        ps2_clk = 1'b1;
        if (rep) check("kv_latency", lat, FILT + 3);
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic good(input logic [7:0] b, input bit rep, input logic cs);
        send_frame(b, 1'b0, 1'b0, rep, cs, 1'b0);
    endtask

    initial begin
        clk      = 1'b0;
        rst_n    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_scan", {24'd0, scan_code}, 32'd0);
        check("rst_kv", {31'd0, key_valid}, 32'd0);
        check("rst_case", {31'd0, letter_case}, 32'd0);
        check("rst_caps", {31'd0, caps_lock}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // Single make code
        good(8'h1C, 1, 1'b0);

        // Shift make/break around a letter
        good(8'h12, 0, 1'b0);
        good(8'h1C, 1, 1'b1);
        good(8'hF0, 0, 1'b0);
        good(8'h1C, 0, 1'b0);
        good(8'hF0, 0, 1'b0);
        good(8'h12, 0, 1'b0);
        good(8'h1C, 1, 1'b0);

        // Caps lock toggle, typematic repeat, release
        good(8'h58, 0, 1'b0);
        check("caps_on", {31'd0, caps_lock}, 32'd1);
        good(8'h58, 0, 1'b0);
        check("caps_repeat", {31'd0, caps_lock}, 32'd1);
        good(8'hF0, 0, 1'b0);
        good(8'h58, 0, 1'b0);
        good(8'h1C, 1, 1'b1);
        good(8'h58, 0, 1'b0);
        check("caps_off", {31'd0, caps_lock}, 32'd0);
        good(8'hF0, 0, 1'b0);
        good(8'h58, 0, 1'b0);
        good(8'h1C, 1, 1'b0);

        // Bad parity and bad stop bit
        err_exp++;
        send_frame(8'h29, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("ferr_parity", err_seen, err_exp);
        check("scan_hold_par", {24'd0, scan_code}, 32'h1C);
        err_exp++;
        send_frame(8'h29, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("ferr_stop", err_seen, err_exp);
        check("scan_hold_stop", {24'd0, scan_code}, 32'h1C);

        // Truncated frame: start + 4 data bits, then the line idles
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1, 1'b0);
        err_exp++;
        repeat (TMO + 10) @(negedge clk);
        check("ferr_timeout", err_seen, err_exp);
        good(8'h16, 1, 1'b0);

        // Extended codes are swallowed
        good(8'hE0, 0, 1'b0);
        good(8'h75, 0, 1'b0);
        good(8'hE0, 0, 1'b0);
        good(8'hF0, 0, 1'b0);
        good(8'h75, 0, 1'b0);
        check("ext_no_err", err_seen, err_exp);

        // Short clock glitches in every high phase must not shift bits
        send_frame(8'h1C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("glitch_no_err", err_seen, err_exp);

        // Reset mid-frame of 0xFF; the leftover bits are all ones
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_scan", {24'd0, scan_code}, 32'd0);
        check("mid_rst_kv", {31'd0, key_valid}, 32'd0);
        check("mid_rst_case", {31'd0, letter_case}, 32'd0);
        check("mid_rst_caps", {31'd0, caps_lock}, 32'd0);
        check("mid_rst_ferr", {31'd0, frame_err}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) ps2_bit(1'b1, 1'b0);
        repeat (2 * HALF) @(negedge clk);
        check("post_rst_scan", {24'd0, scan_code}, 32'd0);
        good(8'h16, 1, 1'b0);

        repeat (100) @(negedge clk);
        check("sb_empty", sb_q.size(), 0);
        check("ferr_total", err_seen, err_exp);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keyboard_ps2_decoder.md
KEYBOARD_PS2_DECODER -- requirements
Module: keyboard_ps2_decoder

Interface
REQ-001 The block SHALL have parameter FILTER_LEN, default 8: consecutive equal samples of synchronized ps2_clk required before the filtered clock changes level.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 50000: maximum number of clk cycles between falling edges inside a frame.
REQ-003 The block SHALL have port clk, input, 1 bit: single system clock, rising-edge active.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous reset, active-low.
REQ-005 The block SHALL have port ps2_clk, input, 1 bit: PS/2 device clock, asynchronous to clk.
REQ-006 The block SHALL have port ps2_data, input, 1 bit: PS/2 device data, asynchronous to clk.
REQ-007 The block SHALL have port scan_code, output, 8 bits: last reported make code, set-2.
REQ-008 The block SHALL have port key_valid, output, 1 bit: one-cycle strobe; scan_code and letter_case are valid while it is high.
REQ-009 The block SHALL have port letter_case, output, 1 bit: (left_shift OR right_shift) XOR caps_lock, captured together with scan_code.
REQ-010 The block SHALL have port caps_lock, output, 1 bit: current caps-lock toggle state.
REQ-011 The block SHALL have port frame_err, output, 1 bit: one-cycle strobe raised when a frame is discarded.

Function
REQ-012 The block SHALL pass ps2_clk and ps2_data through 2-flop synchronizers each.
REQ-013 The block SHALL change the filtered clock level only after FILTER_LEN consecutive equal synchronized samples.
REQ-014 The block SHALL define a falling edge as the cycle in which the filtered clock goes 1->0; ps2_data (synchronized) SHALL be sampled in that cycle.
REQ-015 The receiver FSM SHALL have states IDLE, DATA, PARITY, STOP.
REQ-016 In IDLE, a falling edge with data=0 SHALL go to DATA with bit count 0; with data=1 the FSM SHALL stay in IDLE with no error.
REQ-017 In DATA, each falling edge SHALL shift in one bit LSB-first; after the 8th bit the FSM SHALL go to PARITY.
REQ-018 In PARITY, the sampled bit SHALL be stored and the FSM SHALL go to STOP.
REQ-019 In STOP, the byte SHALL be accepted when the stop bit is 1 and the 8 data bits plus parity have odd weight; otherwise frame_err SHALL pulse and the byte SHALL be dropped; in either case the FSM SHALL return to IDLE.
REQ-020 In any state other than IDLE, TIMEOUT_CYCLES clk cycles without a falling edge SHALL force IDLE and pulse frame_err once.
REQ-021 An accepted byte SHALL be presented internally to the decoder 1 cycle after the STOP edge cycle E.
REQ-022 key_valid SHALL be high exactly at cycle E+2 when the byte produces a report.
REQ-023 Decoder byte F0 SHALL set break_pend and produce no report.
REQ-024 Decoder byte E0 SHALL set ext_pend and produce no report.
REQ-025 Any byte received with ext_pend=1 SHALL produce no report and SHALL clear both pending flags; F0 itself leaves ext_pend set.
REQ-026 With break_pend=1: 12 SHALL clear left_shift, 59 SHALL clear right_shift, 58 SHALL clear caps_held; no report SHALL be produced and break_pend SHALL clear.
REQ-027 Make 12 SHALL set left_shift and make 59 SHALL set right_shift, with no report.
REQ-028 Make 58 SHALL toggle caps_lock only when caps_held=0, then set caps_held, with no report; typematic repeats SHALL NOT re-toggle.
REQ-029 Any other make byte SHALL load scan_code, load letter_case from the shift/caps state before that byte, and pulse key_valid; typematic repeats SHALL report each time.
REQ-030 scan_code and letter_case SHALL hold their values between reports.
REQ-031 frame_err and key_valid SHALL never be high in the same cycle.

Reset
REQ-032 While rst_n=0, every register SHALL clear immediately: FSM to IDLE, bit count 0, filters to 1, scan_code=0x00, key_valid=0, letter_case=0, caps_lock=0, frame_err=0, shift, caps_held and pending flags 0.
REQ-033 After reset deassertion mid-frame, leftover edges of the aborted frame SHALL be handled only per REQ-016/REQ-020; the block SHALL NOT produce a report from a partial frame.

Verification
REQ-034 Frame 0x1C with correct parity -> key_valid at E+2, scan_code=0x1C, letter_case=0, frame_err=0.
REQ-035 Sequence 12, 1C, F0 1C, F0 12, 1C -> first report 0x1C with letter_case=1, second report 0x1C with letter_case=0, no report on break codes.
REQ-036 Sequence 58, 58, F0 58, 1C, then 58, F0 58, 1C -> caps_lock 1 after the first 58 (not re-toggled by the repeat), reports 0x1C with letter_case=1, then caps_lock 0 and the next 0x1C report has letter_case=0.
REQ-037 Frame 0x29 with bad parity, and separately a frame with stop=0 -> frame_err pulse of 1 cycle, no key_valid, scan_code unchanged.
REQ-038 Start plus 4 data bits then ps2_clk held high for TIMEOUT_CYCLES+10 -> one frame_err pulse, FSM in IDLE, next good frame 0x16 reported correctly.
REQ-039 E0 75, E0 F0 75, then 3-cycle glitches on ps2_clk with FILTER_LEN=8, then rst_n pulsed low mid-frame -> no reports, no bit shifted by the glitches, all outputs 0 during reset.
